// File: rtl/proc_launch_pkg.sv
// Shared types and default timing constants for the processor launch controller.
package proc_launch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RECORD,
        GAP,
        DONE
    } state_t;

    localparam int DEF_START_CYCLES = 2;
    localparam int DEF_GAP_CYCLES   = 1;
    localparam int DEF_TIMEOUT      = 16'hFFFF;

    // Width of the inline LAUNCH/GAP phase counter (phase lengths are 1..15).
    localparam int PH_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clr,
    input  logic         Inc,
    output logic [W-1:0] Q
);

    // Count up on Inc, clear takes priority, never wrap past all-ones.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            Q <= '0;
        end else if (Clr) begin
            Q <= '0;
        end else if (Inc && (Q != '1)) begin
            Q <= Q + W'(1);
        end
    end

endmodule

// File: rtl/proc_launch_ctrl.sv
// Host-side Start/Ack initiator: launches a batch of programs back to back, times each
// one in WAIT cycles, reports a result per program and aborts the batch on a timeout.
module proc_launch_ctrl
    import proc_launch_pkg::*;
#(
    parameter int IDX_W        = 2,
    parameter int CNT_W        = 16,
    parameter int START_CYCLES = DEF_START_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic [IDX_W:0]   NumProgs,
    input  logic             Abort,
    input  logic             Ack,
    output logic             Start,
    output logic             Busy,
    output logic [IDX_W-1:0] ProgIdx,
    output logic             ResultValid,
    output logic [CNT_W-1:0] ResultCycles,
    output logic [IDX_W-1:0] ResultProg,
    output logic             AllDone,
    output logic             Error
);

    state_t           state, state_n;
    logic [IDX_W:0]   num_progs;
    logic [PH_W-1:0]  ph_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic [IDX_W:0]   idx_next_ext;
    logic             wait_clr, wait_inc;
    logic             take_go, ack_hit, timeout_hit, last_prog, ph_done;

    // Wait counter runs only in WAIT and restarts from zero on every WAIT entry.
    assign wait_clr = (state != WAIT);
    assign wait_inc = (state == WAIT);

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (wait_clr),
        .Inc   (wait_inc),
        .Q     (wait_cnt)
    );

    assign idx_next_ext = {1'b0, ProgIdx} + {{IDX_W{1'b0}}, 1'b1};
    assign last_prog    = (idx_next_ext == num_progs);

    // Next-state decode; Abort overrides every other transition and event.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_n     = state;
        take_go     = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        ph_done     = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (Go) begin
                    take_go = 1'b1;
                    state_n = (NumProgs == '0) ? DONE : LAUNCH;
                end
            end
            LAUNCH: begin
                // Ack is deliberately ignored here; it may still be high from the previous program.
                ph_done = (ph_cnt == PH_W'(START_CYCLES - 1));
                if (ph_done) state_n = WAIT;
            end
            WAIT: begin
                if (Ack) begin
                    ack_hit = 1'b1;
                    state_n = RECORD;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = RECORD;
                end
            end
            RECORD: begin
                state_n = (Error || last_prog) ? DONE : GAP;
            end
            GAP: begin
                ph_done = (ph_cnt == PH_W'(GAP_CYCLES - 1));
                if (ph_done) state_n = LAUNCH;
            end
            default: state_n = IDLE;
        endcase

        if (Abort) begin
            state_n     = IDLE;
            take_go     = 1'b0;
            ack_hit     = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    // State, phase counter and registered outputs, all decoded from the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            ph_cnt       <= '0;
            num_progs    <= '0;
            Start        <= 1'b0;
            Busy         <= 1'b0;
            AllDone      <= 1'b0;
            ResultValid  <= 1'b0;
            ProgIdx      <= '0;
            ResultCycles <= '0;
            ResultProg   <= '0;
            Error        <= 1'b0;
        end else begin
            state <= state_n;

            if ((state_n == state) && ((state == LAUNCH) || (state == GAP))) begin
                ph_cnt <= ph_cnt + PH_W'(1);
            end else begin
                ph_cnt <= '0;
            end

            Start       <= (state_n == LAUNCH);
            Busy        <= (state_n inside {LAUNCH, WAIT, RECORD, GAP});
            AllDone     <= (state_n == DONE);
            ResultValid <= (state_n == RECORD);

            if (take_go) begin
                num_progs <= NumProgs;
                ProgIdx   <= '0;
                Error     <= 1'b0;
            end

            if ((state == GAP) && (state_n == LAUNCH)) begin
                ProgIdx <= ProgIdx + IDX_W'(1);
            end

            if (ack_hit) begin
                ResultCycles <= wait_cnt + CNT_W'(1);
                ResultProg   <= ProgIdx;
            end else if (timeout_hit) begin
                ResultCycles <= CNT_W'(TIMEOUT);
                ResultProg   <= ProgIdx;
                Error        <= 1'b1;
            end
        end
    end

endmodule
